dac_dual_buffer: RTL and testbench

// - Ping-pong playback buffer feeding a 12-bit DAC. The MCU fills the back buffer over the en/addr_en/rd_en/wr_en bus, then commits it.
// - On each dac_clk rising edge the block streams the front buffer, looping. Committed buffers swap in only at loop wrap, so frames switch glitch-free.
// - Sits between the MCU bus decoder and the DAC pins; it is the output-side counterpart of the ADC capture buffer.

---
 rtl/dac_buf_pkg.sv | 25 ++
 rtl/simple_dp_ram.sv | 43 ++++
 rtl/dac_dual_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_dac_dual_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_buf_pkg.sv
// ---------------------------------------------------------------------------
// dac_buf_pkg
// Shared types and constants for the DAC ping-pong playback buffer.
//   state_t      : playback FSM state (IDLE / PLAY)
//   *_ADDR       : MCU register addresses (addr[14]=1 register space)
//   CTRL_*_BIT   : bit positions inside the CTRL register
//   DAC_MID      : mid-scale DAC code driven while idle / in reset
// ---------------------------------------------------------------------------
package dac_buf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [15:0] CTRL_ADDR   = 16'h4000;
  localparam logic [15:0] STATUS_ADDR = 16'h4001;
  localparam logic [15:0] LEN_ADDR    = 16'h4002;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_STOP_BIT   = 1;

  localparam logic [11:0] DAC_MID = 12'h800;

endpackage

// File: rtl/simple_dp_ram.sv
// ---------------------------------------------------------------------------
// simple_dp_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output (one clock read latency), written so it maps onto block RAM.
// Contents are not reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable (output register only loads when set)
//   raddr  : read address
//   rdata  : registered read data, valid one clock after re
// ---------------------------------------------------------------------------
module simple_dp_ram #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dac_dual_buffer.sv
// ---------------------------------------------------------------------------
// dac_dual_buffer
// Ping-pong playback buffer for a DAC. The MCU fills the back half of the
// sample RAM and commits it; the front half is streamed one sample per
// dac_clk rising edge, looping over play_len samples. A committed buffer
// only becomes the front buffer when the output pointer wraps, so frames
// change without glitches.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   en         : bus access enable, gates addr_en / rd_en / wr_en
//   addr_en    : latch address from rd_data
//   rd_en      : MCU write cycle, data on rd_data
//   wr_en      : MCU read cycle, wr_data updated one clock later
//   dac_clk    : sample strobe (synchronous to clk), rising edge used
//   rd_data    : data / address from MCU
//   wr_data    : read data to MCU (reset 16'hFFFF)
//   dac_data   : DAC sample (reset / idle mid-scale)
//   frame_sync : one-clock pulse aligned with the first sample of a frame
// ---------------------------------------------------------------------------
module dac_dual_buffer
  import dac_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_SIZE   = 1024,
  parameter int DAC_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  addr_en,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic                  dac_clk,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DAC_WIDTH-1:0]  dac_data,
  output logic                  frame_sync
);

  localparam int AW = $clog2(BUF_SIZE);

  localparam logic [AW:0]           LEN_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]           LEN_MAX    = (AW + 1)'(BUF_SIZE);
  localparam logic [DATA_WIDTH-1:0] BUF_SIZE_W = DATA_WIDTH'(BUF_SIZE);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [DAC_WIDTH-1:0]  MID        = DAC_WIDTH'(DAC_MID);

  // Registers
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DAC_WIDTH-1:0]  dac_data_q, dac_data_d;
  logic                  frame_sync_q, frame_sync_d;
  logic                  dac_clk_q, dac_clk_d;
  logic                  front_q, front_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  write_err_q, write_err_d;
  logic [AW:0]           len_q, len_d;
  logic [AW:0]           play_len_q, play_len_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  first_q, first_d;

  // Decode
  logic                 bus_wr, bus_rd, sample_sel;
  logic                 ctrl_wr, len_wr, commit_req, stop_req, commit_acc;
  logic                 dac_rise, at_last;
  logic                 ram_we, ram_re;
  logic [DAC_WIDTH-1:0] ram_rdata;
  logic [3:0]           status;

  assign bus_wr     = en & rd_en;
  assign bus_rd     = en & wr_en;
  assign sample_sel = ~addr_q[14];
  assign ctrl_wr    = bus_wr && (addr_q == CTRL_ADDR);
  assign len_wr     = bus_wr && (addr_q == LEN_ADDR);
  assign commit_req = ctrl_wr & rd_data[CTRL_COMMIT_BIT];
  assign stop_req   = ctrl_wr & rd_data[CTRL_STOP_BIT];
  // A commit is only accepted while no earlier commit is still waiting.
  assign commit_acc = commit_req & ~swap_pending_q;
  assign dac_rise   = dac_clk & ~dac_clk_q;
  assign at_last    = ({1'b0, rd_ptr_q} == (play_len_q - LEN_ONE));
  // Samples landing while a swap is pending would corrupt the committed
  // frame, so they are dropped.
  assign ram_we     = bus_wr & sample_sel & ~swap_pending_q;
  assign status     = {front_q, write_err_q, (state_q == PLAY), ~swap_pending_q};

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wr_data_d      = wr_data_q;
    dac_data_d     = dac_data_q;
    frame_sync_d   = 1'b0;
    dac_clk_d      = dac_clk;
    front_d        = front_q;
    swap_pending_d = swap_pending_q;
    write_err_d    = write_err_q;
    len_d          = len_q;
    play_len_d     = play_len_q;
    rd_ptr_d       = rd_ptr_q;
    rd_valid_d     = 1'b0;
    first_d        = first_q;
    ram_re         = 1'b0;

    // Bus side. A write in the same cycle as addr_en uses the old address.
    if (en & addr_en) begin
      addr_d = rd_data;
    end

    if (bus_wr & sample_sel & swap_pending_q) begin
      write_err_d = 1'b1;
    end

    if (len_wr) begin
      if (rd_data == '0) begin
        len_d = LEN_ONE;
      end else if (rd_data > BUF_SIZE_W) begin
        len_d = LEN_MAX;
      end else begin
        len_d = (AW + 1)'(rd_data);
      end
    end

    if (bus_rd) begin
      if (sample_sel) begin
        wr_data_d = ALL_ONES;
      end else if (addr_q == STATUS_ADDR) begin
        wr_data_d = DATA_WIDTH'(status);
      end else if (addr_q == LEN_ADDR) begin
        wr_data_d = DATA_WIDTH'(len_q);
      end else begin
        wr_data_d = ALL_ONES;
      end
    end

    // Output stage of the playback pipeline: RAM data registered last cycle
    // moves to the DAC pins together with its frame marker.
    if (rd_valid_q) begin
      dac_data_d   = ram_rdata;
      frame_sync_d = first_q;
    end

    case (state_q)
      IDLE: begin
        rd_ptr_d     = '0;
        dac_data_d   = MID;
        frame_sync_d = 1'b0;
        if (stop_req) begin
          // Stop wins over a simultaneous commit, which is kept as pending.
          if (commit_acc) begin
            swap_pending_d = 1'b1;
            write_err_d    = 1'b0;
          end
        end else if (commit_req) begin
          // Nothing is playing, so the (possibly already pending) back
          // buffer is swapped in straight away.
          front_d        = ~front_q;
          play_len_d     = len_q;
          swap_pending_d = 1'b0;
          write_err_d    = 1'b0;
          state_d        = PLAY;
        end
      end

      PLAY: begin
        if (stop_req) begin
          state_d      = IDLE;
          dac_data_d   = MID;
          frame_sync_d = 1'b0;
          rd_ptr_d     = '0;
          if (commit_acc) begin
            swap_pending_d = 1'b1;
            write_err_d    = 1'b0;
          end
        end else begin
          if (commit_acc) begin
            swap_pending_d = 1'b1;
            write_err_d    = 1'b0;
          end
          if (dac_rise) begin
            ram_re     = 1'b1;
            rd_valid_d = 1'b1;
            first_d    = (rd_ptr_q == '0);
            if (at_last) begin
              rd_ptr_d = '0;
              // A commit arriving on the wrap cycle still makes this wrap.
              if (swap_pending_q | commit_acc) begin
                front_d        = ~front_q;
                play_len_d     = len_q;
                swap_pending_d = 1'b0;
              end
            end else begin
              rd_ptr_d = rd_ptr_q + AW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wr_data_q      <= ALL_ONES;
      dac_data_q     <= MID;
      frame_sync_q   <= 1'b0;
      dac_clk_q      <= 1'b0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      write_err_q    <= 1'b0;
      len_q          <= LEN_MAX;
      play_len_q     <= LEN_MAX;
      rd_ptr_q       <= '0;
      rd_valid_q     <= 1'b0;
      first_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wr_data_q      <= wr_data_d;
      dac_data_q     <= dac_data_d;
      frame_sync_q   <= frame_sync_d;
      dac_clk_q      <= dac_clk_d;
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      write_err_q    <= write_err_d;
      len_q          <= len_d;
      play_len_q     <= play_len_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_valid_q     <= rd_valid_d;
      first_q        <= first_d;
    end
  end

  // Lower half of the RAM is buffer 0, upper half buffer 1.
  simple_dp_ram #(
    .WIDTH  (DAC_WIDTH),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({~front_q, addr_q[AW-1:0]}),
    .wdata (rd_data[DAC_WIDTH-1:0]),
    .re    (ram_re),
    .raddr ({front_q, rd_ptr_q}),
    .rdata (ram_rdata)
  );

  assign wr_data    = wr_data_q;
  assign dac_data   = dac_data_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_dac_dual_buffer.sv
module tb_dac_dual_buffer;

  localparam logic [15:0] CTRL   = 16'h4000;
  localparam logic [15:0] STATUS = 16'h4001;
  localparam logic [15:0] LEN    = 16'h4002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, addr_en = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic        dac_clk = 1'b0;
  logic [15:0] rd_data = '0;
  logic [15:0] wr_data;
  logic [11:0] dac_data;
  logic        frame_sync;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] last_exp = 12'h800;

  always #5 clk = ~clk;

  dac_dual_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .addr_en    (addr_en),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .dac_clk    (dac_clk),
    .rd_data    (rd_data),
    .wr_data    (wr_data),
    .dac_data   (dac_data),
    .frame_sync (frame_sync)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    en = 1'b1; addr_en = 1'b1; rd_data = a;
    tick();
    addr_en = 1'b0; rd_en = 1'b1; rd_data = d;
    tick();
    rd_en = 1'b0; en = 1'b0; rd_data = '0;
    $display("bus write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    en = 1'b1; addr_en = 1'b1; rd_data = a;
    tick();
    addr_en = 1'b0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; en = 1'b0; rd_data = '0;
    d = wr_data;
    $display("bus read  addr=%h data=%h", a, d);
  endtask

  // One dac_clk strobe; returns outputs 1 clk and 2 clk after the edge.
  // Optionally drives a CTRL commit in the same cycle as the edge.
  task automatic dac_step(input bit with_commit,
                          output logic [11:0] mid_d, output logic mid_fs,
                          output logic [11:0] d, output logic fs);
    if (with_commit) begin
      en = 1'b1; addr_en = 1'b1; rd_data = CTRL;
      tick();
      addr_en = 1'b0; rd_en = 1'b1; rd_data = 16'h0001;
    end
    dac_clk = 1'b1;
    tick();
    rd_en = 1'b0; en = 1'b0; rd_data = '0;
    mid_d = dac_data; mid_fs = frame_sync;
    dac_clk = 1'b0;
    tick();
    d = dac_data; fs = frame_sync;
    $display("dac step commit=%0b -> data=%h fs=%b", with_commit, d, fs);
  endtask

  task automatic test_reset();
    logic [15:0] r;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (dac_data !== 12'h800) begin n_fail++; $display("FAIL reset_dac: got %h need 800", dac_data); end
    n_cmp++; if (wr_data !== 16'hFFFF) begin n_fail++; $display("FAIL reset_wr_data: got %h need ffff", wr_data); end
    n_cmp++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b need 0", frame_sync); end
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0001) begin n_fail++; $display("FAIL reset_status: got %h need 0001", r); end
    bus_read(LEN, r);
    n_cmp++; if (r !== 16'h0400) begin n_fail++; $display("FAIL reset_len: got %h need 0400", r); end
    bus_read(16'h0003, r);
    n_cmp++; if (r !== 16'hFFFF) begin n_fail++; $display("FAIL sample_read: got %h need ffff", r); end
    bus_read(CTRL, r);
    n_cmp++; if (r !== 16'hFFFF) begin n_fail++; $display("FAIL ctrl_read: got %h need ffff", r); end
    last_exp = 12'h800;
  endtask

  task automatic test_play();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    logic [11:0] exp_d  [6] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h001, 12'h002};
    logic        exp_fs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus_write(LEN, 16'd4);
    for (int i = 0; i < 4; i++) bus_write(16'(i), 16'(i + 1));
    bus_write(CTRL, 16'h0001);
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h000B) begin n_fail++; $display("FAIL play_status: got %h need 000b", r); end
    for (int i = 0; i < 6; i++) begin
      dac_step(1'b0, md, mfs, d, fs);
      n_cmp++; if (md !== last_exp || mfs !== 1'b0) begin n_fail++; $display("FAIL play_latency[%0d]: got %h/%b need %h/0", i, md, mfs, last_exp); end
      n_cmp++; if (d !== exp_d[i] || fs !== exp_fs[i]) begin n_fail++; $display("FAIL play_sample[%0d]: got %h/%b need %h/%b", i, d, fs, exp_d[i], exp_fs[i]); end
      last_exp = exp_d[i];
    end
  endtask

  task automatic test_swap();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    logic [11:0] exp_d  [6] = '{12'h003, 12'h004, 12'h010, 12'h020, 12'h010, 12'h020};
    logic        exp_fs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) bus_write(16'(i), 16'((i + 1) * 16));
    bus_write(LEN, 16'd2);
    bus_write(CTRL, 16'h0001);
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h000A) begin n_fail++; $display("FAIL swap_pending_status: got %h need 000a", r); end
    for (int i = 0; i < 6; i++) begin
      dac_step(1'b0, md, mfs, d, fs);
      n_cmp++; if (md !== last_exp || mfs !== 1'b0) begin n_fail++; $display("FAIL swap_latency[%0d]: got %h/%b need %h/0", i, md, mfs, last_exp); end
      n_cmp++; if (d !== exp_d[i] || fs !== exp_fs[i]) begin n_fail++; $display("FAIL swap_sample[%0d]: got %h/%b need %h/%b", i, d, fs, exp_d[i], exp_fs[i]); end
      last_exp = exp_d[i];
    end
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0003) begin n_fail++; $display("FAIL swap_done_status: got %h need 0003", r); end
  endtask

  task automatic test_write_err();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    logic [11:0] exp_d  [6] = '{12'h010, 12'h020, 12'h055, 12'h066, 12'h055, 12'h066};
    logic        exp_fs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus_write(16'h0000, 16'h0055);
    bus_write(16'h0001, 16'h0066);
    bus_write(CTRL, 16'h0001);
    bus_write(16'h0000, 16'h0077);
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0006) begin n_fail++; $display("FAIL werr_status: got %h need 0006", r); end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        bus_read(STATUS, r);
        n_cmp++; if (r !== 16'h000F) begin n_fail++; $display("FAIL werr_sticky: got %h need 000f", r); end
        bus_write(CTRL, 16'h0001);
        bus_read(STATUS, r);
        n_cmp++; if (r !== 16'h000A) begin n_fail++; $display("FAIL werr_cleared: got %h need 000a", r); end
      end
      dac_step(1'b0, md, mfs, d, fs);
      n_cmp++; if (d !== exp_d[i] || fs !== exp_fs[i]) begin n_fail++; $display("FAIL werr_sample[%0d]: got %h/%b need %h/%b", i, d, fs, exp_d[i], exp_fs[i]); end
      last_exp = exp_d[i];
    end
  endtask

  task automatic test_len_clamp();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    logic [11:0] exp_d  [5] = '{12'h010, 12'h020, 12'h055, 12'h055, 12'h055};
    logic        exp_fs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus_write(LEN, 16'h0800);
    bus_read(LEN, r);
    n_cmp++; if (r !== 16'h0400) begin n_fail++; $display("FAIL len_clamp_hi: got %h need 0400", r); end
    bus_write(LEN, 16'h0003);
    bus_read(LEN, r);
    n_cmp++; if (r !== 16'h0003) begin n_fail++; $display("FAIL len_mid: got %h need 0003", r); end
    bus_write(LEN, 16'h0000);
    bus_read(LEN, r);
    n_cmp++; if (r !== 16'h0001) begin n_fail++; $display("FAIL len_clamp_lo: got %h need 0001", r); end
    // Step 1 carries a commit in the wrap cycle: the swap must happen there.
    for (int i = 0; i < 5; i++) begin
      dac_step(i == 1, md, mfs, d, fs);
      n_cmp++; if (md !== last_exp || mfs !== 1'b0) begin n_fail++; $display("FAIL len_latency[%0d]: got %h/%b need %h/0", i, md, mfs, last_exp); end
      n_cmp++; if (d !== exp_d[i] || fs !== exp_fs[i]) begin n_fail++; $display("FAIL len_sample[%0d]: got %h/%b need %h/%b", i, d, fs, exp_d[i], exp_fs[i]); end
      last_exp = exp_d[i];
    end
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h000B) begin n_fail++; $display("FAIL len_status: got %h need 000b", r); end
  endtask

  task automatic test_stop();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    logic [11:0] exp_d  [3] = '{12'h055, 12'h010, 12'h020};
    logic        exp_fs [3] = '{1'b1, 1'b1, 1'b0};
    bus_write(LEN, 16'd4);
    bus_write(CTRL, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      dac_step(1'b0, md, mfs, d, fs);
      n_cmp++; if (d !== exp_d[i] || fs !== exp_fs[i]) begin n_fail++; $display("FAIL stop_pre[%0d]: got %h/%b need %h/%b", i, d, fs, exp_d[i], exp_fs[i]); end
    end
    bus_write(CTRL, 16'h0002);
    n_cmp++; if (dac_data !== 12'h800) begin n_fail++; $display("FAIL stop_dac: got %h need 800", dac_data); end
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0001) begin n_fail++; $display("FAIL stop_status: got %h need 0001", r); end
    dac_step(1'b0, md, mfs, d, fs);
    n_cmp++; if (d !== 12'h800 || fs !== 1'b0) begin n_fail++; $display("FAIL stop_idle_step: got %h/%b need 800/0", d, fs); end
    bus_write(CTRL, 16'h0001);
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h000B) begin n_fail++; $display("FAIL restart_status: got %h need 000b", r); end
    dac_step(1'b0, md, mfs, d, fs);
    n_cmp++; if (d !== 12'h055 || fs !== 1'b1) begin n_fail++; $display("FAIL restart_s0: got %h/%b need 055/1", d, fs); end
    dac_step(1'b0, md, mfs, d, fs);
    n_cmp++; if (d !== 12'h066 || fs !== 1'b0) begin n_fail++; $display("FAIL restart_s1: got %h/%b need 066/0", d, fs); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    dac_clk = 1'b1;
    tick();
    dac_clk = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted mid-play");
    n_cmp++; if (dac_data !== 12'h800) begin n_fail++; $display("FAIL rstmid_dac: got %h need 800", dac_data); end
    n_cmp++; if (wr_data !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_wr_data: got %h need ffff", wr_data); end
    n_cmp++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL rstmid_fs: got %b need 0", frame_sync); end
    tick();
    rst = 1'b0;
    tick();
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0001) begin n_fail++; $display("FAIL rstmid_status: got %h need 0001", r); end
    bus_read(LEN, r);
    n_cmp++; if (r !== 16'h0400) begin n_fail++; $display("FAIL rstmid_len: got %h need 0400", r); end
  endtask

  task automatic test_stop_commit();
    logic [15:0] r;
    logic [11:0] md, d;
    logic        mfs, fs;
    bus_write(LEN, 16'd4);
    for (int i = 0; i < 4; i++) bus_write(16'(i), 16'(i + 10));
    bus_write(CTRL, 16'h0001);
    dac_step(1'b0, md, mfs, d, fs);
    n_cmp++; if (d !== 12'h00A || fs !== 1'b1) begin n_fail++; $display("FAIL sc_first: got %h/%b need 00a/1", d, fs); end
    bus_write(CTRL, 16'h0003);
    n_cmp++; if (dac_data !== 12'h800) begin n_fail++; $display("FAIL sc_dac: got %h need 800", dac_data); end
    bus_read(STATUS, r);
    n_cmp++; if (r !== 16'h0008) begin n_fail++; $display("FAIL sc_status: got %h need 0008", r); end
  endtask

  initial begin
    test_reset();
    test_play();
    test_swap();
    test_write_err();
    test_len_clamp();
    test_stop();
    test_reset_mid();
    test_stop_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
